// File: rtl/mul_post_norm.sv
// mul_post_norm: two-stage elastic pipeline after the significand multiplier.
// Takes the raw PW-bit product, sign and pre-computed exponent, applies the
// one-position post-multiply normalisation and hands an OW-bit significand,
// sticky bit, adjusted exponent and zero flag to the rounder.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_prod, in_exp, in_sign raw product, exponent, sign
//   out_valid / out_ready    downstream handshake
//   out_sig, out_sticky      normalised significand (MSB = hidden bit), sticky
//   out_exp, out_sign        normalised exponent, sign passthrough
//   out_zero                 product was exactly zero
module mul_post_norm #(
   parameter int unsigned PW = 116,
   parameter int unsigned OW = 55,
   parameter int unsigned EW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_prod,
   input  logic [EW-1:0] in_exp,
   input  logic          in_sign,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_sig,
   output logic          out_sticky,
   output logic [EW-1:0] out_exp,
   output logic          out_sign,
   output logic          out_zero
);

   localparam int unsigned HW = OW + 1;

   logic          s1_valid;
   logic [HW-1:0] s1_hi;
   logic          s1_lo_or;
   logic          s1_hi_zero;
   logic [EW-1:0] s1_exp;
   logic          s1_sign;
   logic          s2_valid;

   logic          s1_load;
   logic          s2_load;

   logic [OW-1:0] n_sig;
   logic          n_sticky;
   logic [EW-1:0] n_exp;
   logic          n_zero;

   // Ready whenever some stage can free up this cycle; no path from in_valid.
   assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
   assign s1_load   = in_valid & in_ready;
   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign out_valid = s2_valid;

   // One-position normalisation. A zero product has hi = 0 and lo_or = 0, so
   // the hi[OW] = 0 branch already yields sig = 0, sticky = 0, exp unchanged.
   always_comb begin
      n_sig    = s1_hi[OW-1:0];
      n_sticky = s1_lo_or;
      n_exp    = s1_exp;
      n_zero   = s1_hi_zero & ~s1_lo_or;
      if (s1_hi[OW]) begin
         n_sig    = s1_hi[OW:1];
         n_sticky = s1_hi[0] | s1_lo_or;
         n_exp    = s1_exp + EW'(1);
      end
   end

   // Stage 1: split product into kept window and OR of the discarded tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_hi      <= '0;
         s1_lo_or   <= 1'b0;
         s1_hi_zero <= 1'b0;
         s1_exp     <= '0;
         s1_sign    <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid   <= 1'b1;
            s1_hi      <= in_prod[PW-1:PW-OW-1];
            s1_lo_or   <= |in_prod[PW-OW-2:0];
            s1_hi_zero <= ~|in_prod[PW-1:PW-OW-1];
            s1_exp     <= in_exp;
            s1_sign    <= in_sign;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: output registers, held while stalled or empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         out_sig    <= '0;
         out_sticky <= 1'b0;
         out_exp    <= '0;
         out_sign   <= 1'b0;
         out_zero   <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid   <= 1'b1;
            out_sig    <= n_sig;
            out_sticky <= n_sticky;
            out_exp    <= n_exp;
            out_sign   <= s1_sign;
            out_zero   <= n_zero;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mul_post_norm.sv
module tb_mul_post_norm;

   typedef struct packed {
      logic [115:0] prod;
      logic [12:0]  exp;
      logic         sign;
   } stim_t;

   typedef struct packed {
      logic [54:0] sig;
      logic        sticky;
      logic [12:0] exp;
      logic        sign;
      logic        zero;
   } res_t;

   typedef struct {
      res_t r;
      int   cyc;
   } sb_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [115:0] in_prod;
   logic [12:0]  in_exp;
   logic         in_sign;
   logic         out_valid;
   logic         out_ready;
   logic [54:0]  out_sig;
   logic         out_sticky;
   logic [12:0]  out_exp;
   logic         out_sign;
   logic         out_zero;

   mul_post_norm dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sig(out_sig), .out_sticky(out_sticky), .out_exp(out_exp),
      .out_sign(out_sign), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    accepted = 0;
   bit    drv_en = 1'b0;
   bit    gap_en = 1'b0;
   bit    lat_chk = 1'b0;
   bit    have = 1'b0;
   stim_t cur;
   stim_t stim[$];
   sb_t   q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: product lies in [0,4) with two integer bits; keep the top
   // OW bits below the leading one position (bit 115 or 114), OR the rest.
   function automatic res_t model(input stim_t s);
      res_t         r;
      logic [115:0] two = 116'(1) << 115;
      r.sign = s.sign;
      r.zero = (s.prod == 116'(0));
      if (s.prod >= two) begin
         r.sig    = 55'(s.prod >> 61);
         r.sticky = (s.prod % (116'(1) << 61)) != 116'(0);
         r.exp    = s.exp + 13'd1;
      end else begin
         r.sig    = 55'(s.prod >> 60);
         r.sticky = (s.prod % (116'(1) << 60)) != 116'(0);
         r.exp    = s.exp;
      end
      return r;
   endfunction

   function automatic stim_t rand_stim();
      stim_t        s;
      logic [127:0] w = {$urandom(), $urandom(), $urandom(), $urandom()};
      s.prod = 116'(w);
      case ($urandom_range(0, 5))
         0: s.prod = s.prod >> 1;
         1: s.prod = 116'(0);
         2: s.prod = 116'(w[31:0]);
         3: s.prod = (s.prod >> 2) | (116'(1) << 114);
         default: ;
      endcase
      s.exp  = 13'($urandom());
      s.sign = 1'($urandom());
      return s;
   endfunction

   // Driver: offers queued beats; a transfer is recorded at the negedge
   // before the rising edge where valid & ready will be seen.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!have && stim.size() != 0) begin
            cur  = stim.pop_front();
            have = 1'b1;
         end
         in_valid = have && drv_en && !(gap_en && $urandom_range(0, 3) == 0);
         in_prod  = cur.prod;
         in_exp   = cur.exp;
         in_sign  = cur.sign;
         @(negedge clk);
         if (!rst && in_valid && in_ready) begin
            sb_t e;
            e.r   = model(cur);
            e.cyc = cyc;
            q.push_back(e);
            accepted++;
            have = 1'b0;
         end
      end
   end

   // Monitor: whenever output is valid it must match the oldest pending beat.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 128'(1), 128'(0));
         end else begin
            chk("out_beat", 128'({out_sig, out_sticky, out_exp, out_sign, out_zero}), 128'(q[0].r));
            if (out_ready) begin
               if (lat_chk) chk("latency", 128'(cyc - q[0].cyc), 128'(2));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((stim.size() != 0 || have || q.size() != 0) && t < 2000) begin
         step();
         t++;
      end
      chk("drain_timeout", 128'(t >= 2000), 128'(0));
   endtask

   function automatic stim_t mk(input logic [115:0] p, input logic [12:0] e, input logic s);
      stim_t r;
      r.prod = p;
      r.exp  = e;
      r.sign = s;
      return r;
   endfunction

   initial begin
      int a0, first, last, nv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_exp    = '0;
      in_sign   = 1'b0;
      out_ready = 1'b0;
      cur       = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_sig", 128'(out_sig), 128'(0));
      chk("rst_out_sticky", 128'(out_sticky), 128'(0));
      chk("rst_out_exp", 128'(out_exp), 128'(0));
      chk("rst_out_sign", 128'(out_sign), 128'(0));
      chk("rst_out_zero", 128'(out_zero), 128'(0));

      // Directed vectors with continuous out_ready and latency check.
      step();
      out_ready = 1'b1;
      drv_en    = 1'b1;
      lat_chk   = 1'b1;
      stim.push_back(mk(116'(1) << 114, 13'h3FF, 1'b0));
      stim.push_back(mk((116'(1) << 115) | (116'(1) << 60), 13'h3FF, 1'b1));
      stim.push_back(mk((116'(1) << 114) | 116'(1), 13'h123, 1'b0));
      stim.push_back(mk(116'(0), 13'h055, 1'b1));
      stim.push_back(mk(116'(1) << 115, 13'h1FFF, 1'b0));
      stim.push_back(mk(~116'(0), 13'h0FFF, 1'b1));
      stim.push_back(mk(116'(1), 13'h0001, 1'b0));
      wait_idle();

      // Back-pressure: four beats offered with out_ready low.
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      a0        = accepted;
      for (int i = 0; i < 4; i++) stim.push_back(rand_stim());
      repeat (6) step();
      @(negedge clk);
      chk("stall_accepted", 128'(accepted - a0), 128'(2));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      step();
      out_ready = 1'b1;
      first = -1;
      last  = -1;
      nv    = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            if (first < 0) first = i;
            last = i;
            nv++;
         end
      end
      chk("release_count", 128'(nv), 128'(4));
      chk("release_no_gap", 128'(last - first), 128'(3));
      step();
      wait_idle();

      // Reset with both stages full: everything in flight is discarded.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) stim.push_back(rand_stim());
      repeat (6) step();
      @(negedge clk);
      chk("full_in_ready", 128'(in_ready), 128'(0));
      step();
      rst    = 1'b1;
      drv_en = 1'b0;
      step();
      rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", 128'(out_valid), 128'(0));
      end
      step();
      drv_en = 1'b1;
      wait_idle();
      lat_chk = 1'b1;
      for (int i = 0; i < 6; i++) stim.push_back(rand_stim());
      wait_idle();

      // Random traffic with random back-pressure and input gaps.
      lat_chk = 1'b0;
      gap_en  = 1'b1;
      for (int i = 0; i < 600; i++) begin
         step();
         out_ready = ($urandom_range(0, 3) != 0);
         if (stim.size() < 3) stim.push_back(rand_stim());
      end
      step();
      out_ready = 1'b1;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
